// File: rtl/ga_best_tracker_if.sv
// Sample stream from the GA selection buffer into the best tracker.
// Signals: in_valid (sample present), in_chrom (chromosome), in_fit (signed fitness).
interface ga_best_tracker_if #(
    parameter int CHROM_W = 8,
    parameter int FIT_W   = 27
);
    logic               in_valid;
    logic [CHROM_W-1:0] in_chrom;
    logic [FIT_W-1:0]   in_fit;

    modport master (
        output in_valid,
        output in_chrom,
        output in_fit
    );

    modport slave (
        input in_valid,
        input in_chrom,
        input in_fit
    );
endinterface

// File: rtl/ga_best_tracker.sv
// Tracks the best (chromosome, fitness) pair of a GA run, counts generations
// and raises done on generation limit or fitness stall.
// Ports: clk, reset (async, active-high), start (restart pulse),
//   in_if (sample stream, slave), best/best_fit/best_gen (best individual),
//   gen_count (completed generations), improved (update pulse),
//   running (RUN state), done (DONE state).
module ga_best_tracker #(
    parameter int CHROM_W   = 8,
    parameter int FIT_W     = 27,
    parameter int POP_SIZE  = 16,
    parameter int MAX_GEN   = 64,
    parameter int STALL_GEN = 8,
    localparam int GW = $clog2(MAX_GEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    ga_best_tracker_if.slave   in_if,
    output logic [CHROM_W-1:0] best,
    output logic [FIT_W-1:0]   best_fit,
    output logic [GW-1:0]      best_gen,
    output logic [GW-1:0]      gen_count,
    output logic               improved,
    output logic               running,
    output logic               done
);
    localparam int SW = $clog2(POP_SIZE);
    localparam int TW = $clog2(STALL_GEN + 1);

    localparam logic [GW-1:0] GEN_LIM   = GW'(MAX_GEN);
    localparam logic [SW-1:0] SMP_LAST  = SW'(POP_SIZE - 1);
    localparam logic [TW-1:0] STALL_LIM = TW'(STALL_GEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CHROM_W-1:0] best_q;
    logic [FIT_W-1:0]   best_fit_q;
    logic [GW-1:0]      best_gen_q;
    logic [GW-1:0]      gen_q;
    logic [SW-1:0]      smp_q;
    logic [TW-1:0]      stall_q;
    logic               best_valid_q;
    logic               gen_imp_q;
    logic               improved_q;
    logic               running_q;
    logic               done_q;

    logic               beat_d;
    logic               wrap_d;
    logic               term_d;
    logic [GW-1:0]      gen_d;
    logic [TW-1:0]      stall_d;

    always_comb begin
        // Strict signed compare: ties keep the earlier individual.
        beat_d = !best_valid_q ||
                 ($signed(in_if.in_fit) > $signed(best_fit_q));
        wrap_d = (smp_q == SMP_LAST);
        // Termination looks at the values left by the last boundary.
        term_d = (gen_q == GEN_LIM) || (stall_q == STALL_LIM);
        gen_d  = (gen_q == GEN_LIM) ? gen_q : gen_q + GW'(1);
        // An improvement on the boundary sample itself also resets stall.
        if (gen_imp_q || beat_d) begin
            stall_d = '0;
        end else if (stall_q == STALL_LIM) begin
            stall_d = stall_q;
        end else begin
            stall_d = stall_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            best_q       <= '0;
            best_fit_q   <= '0;
            best_gen_q   <= '0;
            gen_q        <= '0;
            smp_q        <= '0;
            stall_q      <= '0;
            best_valid_q <= 1'b0;
            gen_imp_q    <= 1'b0;
            improved_q   <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            improved_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        running_q    <= 1'b1;
                        done_q       <= 1'b0;
                        best_q       <= '0;
                        best_fit_q   <= '0;
                        best_gen_q   <= '0;
                        gen_q        <= '0;
                        smp_q        <= '0;
                        stall_q      <= '0;
                        best_valid_q <= 1'b0;
                        gen_imp_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (term_d) begin
                        // Any sample in this cycle is dropped.
                        state_q   <= S_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (in_if.in_valid) begin
                        if (beat_d) begin
                            best_q       <= in_if.in_chrom;
                            best_fit_q   <= in_if.in_fit;
                            best_gen_q   <= gen_q;
                            improved_q   <= 1'b1;
                            best_valid_q <= 1'b1;
                            gen_imp_q    <= 1'b1;
                        end
                        if (wrap_d) begin
                            smp_q     <= '0;
                            gen_q     <= gen_d;
                            stall_q   <= stall_d;
                            gen_imp_q <= 1'b0;
                        end else begin
                            smp_q <= smp_q + SW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign best      = best_q;
    assign best_fit  = best_fit_q;
    assign best_gen  = best_gen_q;
    assign gen_count = gen_q;
    assign improved  = improved_q;
    assign running   = running_q;
    assign done      = done_q;
endmodule

// File: tb/tb_ga_best_tracker.sv
// Randomized self-checking bench for ga_best_tracker against a
// behavioural argmax / generation model.
module tb_ga_best_tracker;
    localparam int CW     = 8;
    localparam int FW     = 27;
    localparam int POP    = 16;
    localparam int MAXG   = 64;
    localparam int STALLG = 8;
    localparam int GW     = $clog2(MAXG + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] best;
    logic [FW-1:0] best_fit;
    logic [GW-1:0] best_gen;
    logic [GW-1:0] gen_count;
    logic          improved;
    logic          running;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ga_best_tracker_if #(.CHROM_W(CW), .FIT_W(FW)) bus ();

    ga_best_tracker #(
        .CHROM_W(CW), .FIT_W(FW), .POP_SIZE(POP),
        .MAX_GEN(MAXG), .STALL_GEN(STALLG)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .in_if(bus.slave),
        .best(best), .best_fit(best_fit), .best_gen(best_gen),
        .gen_count(gen_count), .improved(improved),
        .running(running), .done(done)
    );

    // Model: 0 idle, 1 run, 2 done. Stall is derived from the generation
    // of the latest improvement rather than kept as a counter.
    int          m_state;
    logic [7:0]  m_best;
    int          m_fit, m_bgen, m_gen, m_cnt;
    bit          m_bvalid, m_imp;

    task automatic model_clear();
        m_best = 0; m_fit = 0; m_bgen = 0; m_gen = 0; m_cnt = 0;
        m_bvalid = 0; m_imp = 0;
    endtask

    task automatic model_edge(input bit st, input bit v,
                              input logic [7:0] c, input int f);
        m_imp = 0;
        if (m_state == 1) begin
            if (m_gen == MAXG ||
                (m_bvalid && m_gen - m_bgen - 1 == STALLG)) begin
                m_state = 2;
            end else if (v) begin
                if (!m_bvalid || f > m_fit) begin
                    m_best = c; m_fit = f; m_bgen = m_gen;
                    m_bvalid = 1; m_imp = 1;
                end
                m_cnt++;
                if (m_cnt == POP) begin
                    m_cnt = 0;
                    m_gen++;
                end
            end
        end else if (st) begin
            model_clear();
            m_state = 1;
        end
    endtask

    task automatic step(input bit st, input bit v,
                        input logic [7:0] c, input int f);
        start = st;
        bus.in_valid = v;
        bus.in_chrom = c;
        bus.in_fit = f[FW-1:0];
        model_edge(st, v, c, f);
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_state = 0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_chrom = '0; bus.in_fit = '0;
        @(posedge clk);
        #1;
        vectors++;
        if ({best, best_fit, best_gen, gen_count, improved, running, done}
            !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got best=%h fit=%h bg=%0d gc=%0d imp=%b run=%b done=%b, required all 0",
                     best, best_fit, best_gen, gen_count, improved, running, done);
        end
        reset = 1'b0;
        m_state = 0;
        model_clear();
    endtask

    task automatic test_ramp();
        int pulses = 0;
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(i), i);
            if (improved) pulses++;
            vectors++;
            if (improved !== m_imp) begin
                miscompares++;
                $display("FAIL ramp_improved[%0d]: got %b required %b", i, improved, m_imp);
            end
        end
        vectors++;
        if (pulses != 16) begin
            miscompares++;
            $display("FAIL ramp_pulses: got %0d required 16", pulses);
        end
        vectors++;
        if ({best, best_fit, best_gen, gen_count, done} !==
            {8'd15, 27'd15, 7'd0, 7'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL ramp_final: got best=%0d fit=%0d bg=%0d gc=%0d done=%b, required 15 15 0 1 0",
                     best, best_fit, best_gen, gen_count, done);
        end
    endtask

    task automatic test_signed();
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 8'h01, -100);
        step(0, 1, 8'h02, -5);
        step(0, 1, 8'h03, -50);
        vectors++;
        if ($signed(best_fit) !== -27'sd5 || best !== 8'h02) begin
            miscompares++;
            $display("FAIL signed_best: got chrom=%h fit=%0d required 02 -5", best, $signed(best_fit));
        end
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 8'h11, 7);
        vectors++;
        if (improved !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_first_improved: got %b required 1", improved);
        end
        step(0, 1, 8'h22, 7);
        vectors++;
        if (improved !== 1'b0 || best !== 8'h11) begin
            miscompares++;
            $display("FAIL tie_keep: got improved=%b best=%h required 0 11", improved, best);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 8'hA5, 1000);
        for (int i = 1; i < 16 * 9; i++) begin
            step(0, 1, 8'($urandom), int'($urandom_range(1999, 0)) - 1000);
            vectors++;
            if (improved !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_improved[%0d]: got %b required 0", i, improved);
            end
        end
        vectors++;
        if (gen_count !== 7'd9 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_boundary: got gc=%0d done=%b required 9 0", gen_count, done);
        end
        step(0, 1, 8'h5A, 5000);
        vectors++;
        if ({done, running, gen_count, best_gen, best_fit, best} !==
            {1'b1, 1'b0, 7'd9, 7'd0, 27'd1000, 8'hA5}) begin
            miscompares++;
            $display("FAIL stall_done: got done=%b run=%b gc=%0d bg=%0d fit=%0d best=%h required 1 0 9 0 1000 a5",
                     done, running, gen_count, best_gen, best_fit, best);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h77, 9000 + i);
            vectors++;
            if (improved !== 1'b0 || best_fit !== 27'd1000 || done !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_frozen[%0d]: got imp=%b fit=%0d done=%b required 0 1000 1",
                         i, improved, best_fit, done);
            end
        end
    endtask

    task automatic test_gen_limit();
        int f;
        do_reset();
        step(1, 0, 0, 0);
        for (int g = 0; g < MAXG; g++) begin
            for (int s = 0; s < POP; s++) begin
                f = (s == 5) ? g * 100 + 50 : g * 100 + int'($urandom_range(49, 0));
                step(0, 1, 8'($urandom), f);
                vectors++;
                if (improved !== m_imp) begin
                    miscompares++;
                    $display("FAIL limit_improved[%0d.%0d]: got %b required %b", g, s, improved, m_imp);
                end
            end
        end
        vectors++;
        if (gen_count !== 7'd64 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL limit_boundary: got gc=%0d done=%b required 64 0", gen_count, done);
        end
        step(0, 1, 8'h00, 100000);
        vectors++;
        if ({done, gen_count, best_gen, best_fit} !==
            {1'b1, 7'd64, 7'd63, 27'd6350}) begin
            miscompares++;
            $display("FAIL limit_done: got done=%b gc=%0d bg=%0d fit=%0d required 1 64 63 6350",
                     done, gen_count, best_gen, best_fit);
        end
        step(1, 0, 0, 0);
        vectors++;
        if ({running, done, gen_count, best_fit} !== {1'b1, 1'b0, 7'd0, 27'd0}) begin
            miscompares++;
            $display("FAIL restart_from_done: got run=%b done=%b gc=%0d fit=%0d required 1 0 0 0",
                     running, done, gen_count, best_fit);
        end
    endtask

    task automatic test_gapped();
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            step(i == 10, (i % 2) == 0, 8'($urandom),
                 int'($urandom_range(400, 0)) - 200);
        end
        vectors++;
        if ({gen_count, running, best, best_fit} !==
            {GW'(m_gen), 1'b1, m_best, m_fit[FW-1:0]}) begin
            miscompares++;
            $display("FAIL gapped: got gc=%0d run=%b best=%h fit=%0d required %0d 1 %h %0d",
                     gen_count, running, best, $signed(best_fit), m_gen, m_best, m_fit);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        do_reset();
        step(1, 0, 0, 0);
        while (cyc < 3000 && m_state != 2) begin
            step(0, $urandom_range(9, 0) < 7, 8'($urandom),
                 int'($urandom_range(60, 0)) - 30);
            cyc++;
            vectors++;
            if ({best, best_fit, best_gen, gen_count, improved, running, done} !==
                {m_best, m_fit[FW-1:0], GW'(m_bgen), GW'(m_gen), m_imp,
                 m_state == 1, m_state == 2}) begin
                miscompares++;
                $display("FAIL random[%0d]: got best=%h fit=%0d bg=%0d gc=%0d imp=%b run=%b done=%b required %h %0d %0d %0d %b %b %b",
                         cyc, best, $signed(best_fit), best_gen, gen_count, improved,
                         running, done, m_best, m_fit, m_bgen, m_gen, m_imp,
                         m_state == 1, m_state == 2);
            end
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL random_terminate: got done=%b required 1 within 3000 cycles", done);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 8'(i + 1), 10 * i + 3);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({best, best_fit, best_gen, gen_count, improved, running, done}
            !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got best=%h fit=%0d bg=%0d gc=%0d imp=%b run=%b done=%b required all 0",
                     best, best_fit, best_gen, gen_count, improved, running, done);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (improved !== 1'b0 || running !== 1'b0) begin
            miscompares++;
            $display("FAIL async_hold: got imp=%b run=%b required 0 0", improved, running);
        end
        reset = 1'b0;
        m_state = 0;
        model_clear();
        step(1, 0, 0, 0);
        vectors++;
        if ({running, gen_count, best_fit} !== {1'b1, 7'd0, 27'd0}) begin
            miscompares++;
            $display("FAIL async_restart: got run=%b gc=%0d fit=%0d required 1 0 0",
                     running, gen_count, best_fit);
        end
        for (int i = 0; i < 16; i++) step(0, 1, 8'($urandom), int'($urandom_range(99, 0)));
        vectors++;
        if ({gen_count, best, best_fit, best_gen} !==
            {7'd1, m_best, m_fit[FW-1:0], 7'd0}) begin
            miscompares++;
            $display("FAIL async_clean_gen: got gc=%0d best=%h fit=%0d bg=%0d required 1 %h %0d 0",
                     gen_count, best, best_fit, best_gen, m_best, m_fit);
        end
    endtask

    initial begin
        m_state = 0;
        model_clear();
        test_reset();
        test_ramp();
        test_signed();
        test_stall();
        test_gen_limit();
        test_gapped();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
